seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the Basys 3 display path. Holds an NUM_DIGITS-digit hex value, scans the digits one at a time at a programmable refresh rate, and drives active-low anodes and segments directly. Adds tear-free frame-synchronous value loading, per-digit blanking and decimal points, leading-zero suppression and PWM brightness control. Sits between the datapath (counters, mouse/car status) and the board's display pins.

---
 rtl/seg7_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS hex digits onto
// active-low anode/segment pins with frame-synchronous loading, blanking,
// decimal points, leading-zero suppression and PWM brightness.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic                    LOAD_IN,
  input  logic                    LZ_SUPPRESS_IN,
  input  logic [3:0]              BRIGHT_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_DONE_OUT
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, disp_dp, disp_blank;
  logic                    pend_valid;
  logic [DIV_WIDTH-1:0]    refresh_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              pwm_cnt;
  logic                    wrap_d;

  logic                    digit_wrap, frame_wrap;
  logic [NUM_DIGITS-1:0]   zero_run;
  logic                    run_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_sup;
  logic [NUM_DIGITS-1:0]   anode_sel, sel_next;
  logic [6:0]              glyph;
  logic [7:0]              hex_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign digit_wrap = (refresh_cnt == DIV_LAST);
  assign frame_wrap = digit_wrap && (digit_idx == IDX_LAST);

  // Refresh divider, digit index and free-running PWM counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      pwm_cnt     <= 4'd0;
      wrap_d      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      wrap_d  <= frame_wrap;
      if (digit_wrap) begin
        refresh_cnt <= '0;
        digit_idx   <= frame_wrap ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Pending/display registers; display only changes at the frame wrap.
  // A load landing on the wrap itself goes straight to the display.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (frame_wrap) begin
      pend_valid <= 1'b0;
      if (LOAD_IN) begin
        disp_value <= VALUE_IN;
        disp_dp    <= DP_IN;
        disp_blank <= BLANK_IN;
      end else if (pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
    end else if (LOAD_IN) begin
      pend_value <= VALUE_IN;
      pend_dp    <= DP_IN;
      pend_blank <= BLANK_IN;
      pend_valid <= 1'b1;
    end
  end

  // zero_run[k]: display nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_run = '0;
    run_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero    = run_zero & (disp_value[4*k +: 4] == 4'd0);
      zero_run[k] = run_zero;
    end
  end

  // Select the active digit's fields and its one-hot (active-low) anode.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    anode_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib      = disp_value[4*k +: 4];
        cur_dp       = disp_dp[k];
        cur_blank    = disp_blank[k];
        cur_sup      = zero_run[k] && (k != 0);
        anode_sel[k] = 1'b0;
      end
    end
  end

  // Segment/DP pattern and PWM-gated anode for the next output cycle.
  always_comb begin
    glyph    = (LZ_SUPPRESS_IN && cur_sup) ? 7'h7F : decode(cur_nib);
    hex_next = cur_blank ? 8'hFF : {~cur_dp, glyph};
    sel_next = (pwm_cnt <= BRIGHT_IN) ? anode_sel : '1;
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT_OUT <= '1;
      HEX_OUT        <= 8'hFF;
      FRAME_DONE_OUT <= 1'b0;
    end else begin
      SEG_SELECT_OUT <= sel_next;
      HEX_OUT        <= hex_next;
      FRAME_DONE_OUT <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model pushes
// the expected outputs of every cycle; a monitor pops and compares them.
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FP  = N * DIV;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] VALUE_IN = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  BLANK_IN = '0;
  logic        LOAD_IN = 1'b0;
  logic        LZ_SUPPRESS_IN = 1'b0;
  logic [3:0]  BRIGHT_IN = 4'd15;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_DONE_OUT;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .DIV_WIDTH(3)) dut (
    .CLK(CLK), .RESET(RESET), .VALUE_IN(VALUE_IN), .DP_IN(DP_IN),
    .BLANK_IN(BLANK_IN), .LOAD_IN(LOAD_IN), .LZ_SUPPRESS_IN(LZ_SUPPRESS_IN),
    .BRIGHT_IN(BRIGHT_IN), .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT),
    .FRAME_DONE_OUT(FRAME_DONE_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] hex;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Segment table g..a, active low.
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state: cycle number since reset, shown and pending frames.
  int          m_t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  logic        p_valid;

  logic [15:0] cur_v  = '0;
  logic [3:0]  cur_dp = '0;
  logic [3:0]  cur_bl = '0;
  logic        cur_lz = 1'b0;
  logic [3:0]  cur_br = 4'd15;

  function automatic logic [7:0] exp_hex(input int d, input logic [15:0] v,
                                         input logic [3:0] dp, input logic [3:0] bl,
                                         input logic lz);
    logic [6:0] g;
    int nib;
    if (bl[d]) return 8'hFF;
    nib = int'((v >> (4 * d)) & 16'hF);
    g = glyph_tab[nib];
    if (lz && d != 0 && (v >> (4 * d)) == 16'd0) g = 7'h7F;
    return {~dp[d], g};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_val = '0; m_dp = '0; m_bl = '0;
    p_val = '0; p_dp = '0; p_bl = '0; p_valid = 1'b0;
  endtask

  task automatic step(input logic rst, input logic ld);
    exp_t e;
    int d, pw;
    @(negedge CLK);
    RESET = rst; LOAD_IN = ld; VALUE_IN = cur_v; DP_IN = cur_dp;
    BLANK_IN = cur_bl; LZ_SUPPRESS_IN = cur_lz; BRIGHT_IN = cur_br;
    if (rst) begin
      e.sel = 4'hF; e.hex = 8'hFF; e.fd = 1'b0;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    d  = (m_t / DIV) % N;
    pw = m_t % 16;
    e.sel = (4'(pw) <= cur_br) ? (4'hF ^ 4'(1 << d)) : 4'hF;
    e.hex = exp_hex(d, m_val, m_dp, m_bl, cur_lz);
    e.fd  = (m_t > 0) && (m_t % FP == 0);
    exp_q.push_back(e);
    if (ld) begin
      p_val = cur_v; p_dp = cur_dp; p_bl = cur_bl; p_valid = 1'b1;
    end
    if ((m_t + 1) % FP == 0 && p_valid) begin
      m_val = p_val; m_dp = p_dp; m_bl = p_bl; p_valid = 1'b0;
    end
    m_t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    cur_v = v; cur_dp = dp; cur_bl = bl;
    step(1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per clock edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("anodes", {8'h0, SEG_SELECT_OUT}, {8'h0, e.sel});
        chk("hex", {4'h0, HEX_OUT}, {4'h0, e.hex});
        chk("frame_done", {11'h0, FRAME_DONE_OUT}, {11'h0, e.fd});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);

    // Basic scan of 1234, then a mid-frame load of ABCD.
    do_load(16'h1234, 4'h0, 4'h0);
    idle(3 * FP);
    while (m_t % FP != 6) idle(1);
    do_load(16'hABCD, 4'h0, 4'h0);
    idle(2 * FP);

    // Leading-zero suppression, DP on a suppressed digit, value zero.
    cur_lz = 1'b1;
    do_load(16'h0050, 4'b0100, 4'h0);
    idle(2 * FP);
    do_load(16'h0000, 4'h0, 4'h0);
    idle(2 * FP);
    cur_lz = 1'b0;

    // Blanking with all decimal points set.
    do_load(16'h5A3C, 4'b1111, 4'b1010);
    idle(2 * FP);

    // Brightness.
    cur_br = 4'd3;  idle(3 * FP);
    cur_br = 4'd0;  idle(2 * FP);
    cur_br = 4'd15;

    // Load on the exact wrap cycle.
    while (m_t % FP != FP - 1) idle(1);
    do_load(16'h9E07, 4'b0001, 4'h0);
    idle(FP + 2);

    // Pending load then reset in the middle of digit 2.
    while ((m_t / DIV) % N != 1) idle(1);
    do_load(16'h4321, 4'h0, 4'h0);
    while ((m_t / DIV) % N != 2 || m_t % DIV != 1) idle(1);
    step(1'b1, 1'b0);
    idle(3 * FP);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if ($urandom_range(0, 49) == 0) cur_br = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) cur_lz = ~cur_lz;
      if (r < 2) begin
        step(1'b1, 1'b0);
      end else if (r < 80) begin
        cur_v  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
        cur_dp = 4'($urandom);
        cur_bl = 4'($urandom & $urandom);
        step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge CLK);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
